// File: rtl/biu_pkg.sv
// Shared types and defaults for the bus interface unit.
// Holds the bus-cycle state enum, the cycle owner enum and address defaults.
package biu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      T3,
      TW,
      T4
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      EU,
      PF
   } owner_t;

   localparam int          WIDTH_ADDR_DEF    = 20;
   localparam logic [19:0] RESET_ADDRESS_DEF = 20'hFFFF0;

endpackage

// File: rtl/bus_cycle_fsm.sv
// T1..T4 bus-cycle sequencer with a one-cycle cycle_end pulse in T4.
// Wait states (TW) exist only with PREFETCH_SCHEDULER_WAIT_STATE_EN defined.
module bus_cycle_fsm
   import biu_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   start,
   input  logic   bus_ready,
   output state_t state,
   output logic   sample,
   output logic   cycle_end
);

   state_t next;
   logic   ready;

`ifdef PREFETCH_SCHEDULER_WAIT_STATE_EN
   assign ready = bus_ready;
`else
   logic unused_ready;
   assign unused_ready = bus_ready;
   assign ready        = 1'b1;
`endif

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   // next state, data-sample strobe and end-of-cycle pulse
   always_comb begin
      next      = state;
      sample    = 1'b0;
      cycle_end = 1'b0;
      unique case (state)
         IDLE: next = start ? T1 : IDLE;
         T1:   next = T2;
         T2:   next = T3;
         T3, TW: begin
            next   = ready ? T4 : TW;
            sample = ready;
         end
         T4: begin
            next      = start ? T1 : IDLE;
            cycle_end = 1'b1;
         end
         default: next = IDLE;
      endcase
   end

endmodule

// File: rtl/prefetch_scheduler.sv
// Arbitrates EU cycles against instruction prefetch and owns the prefetch pointer.
// Optional wait states: define PREFETCH_SCHEDULER_WAIT_STATE_EN.
module prefetch_scheduler
   import biu_pkg::*;
#(
   parameter int                    WIDTH_ADDR    = WIDTH_ADDR_DEF,
   parameter int                    QUEUE_DEPTH   = 6,
   parameter logic [WIDTH_ADDR-1:0] RESET_ADDRESS = WIDTH_ADDR'(RESET_ADDRESS_DEF)
)(
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             eu_request,
   input  logic                             eu_write,
   input  logic [WIDTH_ADDR-1:0]            eu_address,
   input  logic [7:0]                       eu_wdata,
   output logic                             eu_done,
   output logic [7:0]                       eu_rdata,
   input  logic                             flush,
   input  logic [WIDTH_ADDR-1:0]            flush_address,
   input  logic [$clog2(QUEUE_DEPTH+1)-1:0] q_length,
   output logic                             q_write_enable,
   output logic [7:0]                       q_write_data,
   output logic                             q_clear,
   output logic [WIDTH_ADDR-1:0]            bus_address,
   output logic [7:0]                       bus_wdata,
   output logic                             bus_read,
   output logic                             bus_write,
   input  logic [7:0]                       bus_rdata,
   input  logic                             bus_ready
);

   localparam int QW = $clog2(QUEUE_DEPTH+1);

   state_t                state;
   owner_t                owner;
   logic                  sample;
   logic                  cycle_end;
   logic                  arb;
   logic                  eu_go;
   logic                  pf_go;
   logic                  start;
   logic                  kill;
   logic                  wr_q;
   logic [7:0]            wdata_q;
   logic [QW:0]           occ;
   logic [WIDTH_ADDR-1:0] pf_ptr;
   logic [WIDTH_ADDR-1:0] ptr_nx;

   bus_cycle_fsm u_fsm (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .bus_ready (bus_ready),
      .state     (state),
      .sample    (sample),
      .cycle_end (cycle_end)
   );

   // arbitration, queue push and pointer next value
   always_comb begin
      arb            = (state == IDLE) || cycle_end;
      q_write_enable = cycle_end && (owner == PF) && !kill && !flush;
      occ            = {1'b0, q_length} + {{QW{1'b0}}, q_write_enable};
      // a request being completed in this T4 is not a new request
      eu_go          = arb && eu_request && !(cycle_end && owner == EU);
      pf_go          = arb && !eu_go && !flush &&
                       (occ < (QW+1)'(QUEUE_DEPTH));
      start          = eu_go || pf_go;
      ptr_nx         = pf_ptr;
      if (flush)               ptr_nx = flush_address;
      else if (q_write_enable) ptr_nx = pf_ptr + 1'b1;
   end

   // strobes and completion outputs
   always_comb begin
      bus_read  = (state inside {T2, T3, TW}) && !wr_q;
      bus_write = (state inside {T2, T3, TW}) && wr_q;
      bus_wdata = (wr_q && state != IDLE && state != T1) ? wdata_q : 8'h00;
      eu_done   = cycle_end && (owner == EU);
      q_clear   = flush && reset;
   end

   // prefetch pointer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) pf_ptr <= RESET_ADDRESS;
      else        pf_ptr <= ptr_nx;
   end

   // cycle ownership, latched address/data and flush discard flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner       <= NONE;
         bus_address <= RESET_ADDRESS;
         wr_q        <= 1'b0;
         wdata_q     <= 8'h00;
         kill        <= 1'b0;
      end else if (arb) begin
         owner <= eu_go ? EU : (pf_go ? PF : NONE);
         wr_q  <= eu_go && eu_write;
         kill  <= 1'b0;
         if (eu_go) begin
            bus_address <= eu_address;
            wdata_q     <= eu_wdata;
         end else if (pf_go) begin
            bus_address <= ptr_nx;
         end
      end else if (flush && owner == PF) begin
         kill <= 1'b1;
      end
   end

   // read data capture at the end of the last T3/TW
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         eu_rdata     <= 8'h00;
         q_write_data <= 8'h00;
      end else if (sample && !wr_q) begin
         if (owner == EU) eu_rdata     <= bus_rdata;
         else             q_write_data <= bus_rdata;
      end
   end

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Self-checking bench for prefetch_scheduler: cycle table plus scoreboards.
// Wait-state expectations follow PREFETCH_SCHEDULER_WAIT_STATE_EN.
module tb_prefetch_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        eu_request;
   logic        eu_write;
   logic [19:0] eu_address;
   logic [7:0]  eu_wdata;
   logic        eu_done;
   logic [7:0]  eu_rdata;
   logic        flush;
   logic [19:0] flush_address;
   logic [2:0]  q_length;
   logic        q_write_enable;
   logic [7:0]  q_write_data;
   logic        q_clear;
   logic [19:0] bus_address;
   logic [7:0]  bus_wdata;
   logic        bus_read;
   logic        bus_write;
   logic [7:0]  bus_rdata;
   logic        bus_ready;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [19:0] addr;
      logic [7:0]  data;
      logic        w;
   } sb_t;

   sb_t pf_q[$];
   sb_t eu_q[$];

   typedef struct {
      logic [2:0]  qlen;
      logic        rd;
      logic        qwe;
      logic [19:0] addr;
   } vec_t;

   vec_t tbl[12];

   prefetch_scheduler dut (
      .clock          (clock),
      .reset          (reset),
      .eu_request     (eu_request),
      .eu_write       (eu_write),
      .eu_address     (eu_address),
      .eu_wdata       (eu_wdata),
      .eu_done        (eu_done),
      .eu_rdata       (eu_rdata),
      .flush          (flush),
      .flush_address  (flush_address),
      .q_length       (q_length),
      .q_write_enable (q_write_enable),
      .q_write_data   (q_write_data),
      .q_clear        (q_clear),
      .bus_address    (bus_address),
      .bus_wdata      (bus_wdata),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_rdata      (bus_rdata),
      .bus_ready      (bus_ready)
   );

   always #5 clock = ~clock;

   // memory model: byte = low address byte xor E0
   assign bus_rdata = bus_address[7:0] ^ 8'hE0;

   function automatic void chk(input string name,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // scoreboard consumers
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (q_write_enable) begin
            if (pf_q.size() == 0) begin
               chk("unexpected_push", {12'h0, bus_address}, 32'hFFFFFFFF);
            end else begin
               sb_t e;
               e = pf_q.pop_front();
               chk("push_addr", {12'h0, bus_address}, {12'h0, e.addr});
               chk("push_data", {24'h0, q_write_data}, {24'h0, e.data});
            end
         end
         if (eu_done) begin
            if (eu_q.size() == 0) begin
               chk("unexpected_done", {12'h0, bus_address}, 32'hFFFFFFFF);
            end else begin
               sb_t e;
               e = eu_q.pop_front();
               chk("eu_addr", {12'h0, bus_address}, {12'h0, e.addr});
               if (e.w) chk("eu_wdata", {24'h0, bus_wdata}, {24'h0, e.data});
               else     chk("eu_rdata", {24'h0, eu_rdata}, {24'h0, e.data});
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         cyc();
      end
   endtask

   task automatic wait_pushes(input int n);
      int got;
      got = 0;
      for (int k = 0; k < 40 && got < n; k++) begin
         @(negedge clock);
         if (q_write_enable) begin
            got++;
            if (got == n) q_length = 3'd6;
         end
         cyc();
      end
      chk("push_count", got, n);
   endtask

   task automatic eu_cycle(input logic [19:0] a, input logic w,
                           input logic [7:0] wd, input logic [7:0] exp,
                           input bit stall, input logic [2:0] qlen);
      int  lat;
      int  good;
      int  bad;
      int  exp_lat;
      bit  seen;
      sb_t e;
      e.addr = a;
      e.data = exp;
      e.w    = w;
      eu_q.push_back(e);
      eu_request = 1'b1;
      eu_write   = w;
      eu_address = a;
      eu_wdata   = wd;
      q_length   = qlen;
      seen = 0;
      lat  = 0;
      good = 0;
      bad  = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         bus_ready = !(stall && (k == 3 || k == 4));
         @(negedge clock);
         if (w ? bus_write : bus_read) good++;
         if (w ? bus_read : bus_write) bad++;
         if (eu_done) begin
            seen = 1;
            lat  = k;
         end
         cyc();
      end
      bus_ready  = 1'b1;
      eu_request = 1'b0;
`ifdef PREFETCH_SCHEDULER_WAIT_STATE_EN
      exp_lat = stall ? 6 : 4;
`else
      exp_lat = 4;
`endif
      chk("eu_done_seen", seen, 1);
      chk("eu_latency", lat, exp_lat);
      chk("eu_strobes", good, exp_lat - 2);
      chk("eu_wrong_strobe", bad, 0);
   endtask

   function automatic sb_t pf(input logic [19:0] a, input logic [7:0] d);
      sb_t e;
      e.addr = a;
      e.data = d;
      e.w    = 1'b0;
      return e;
   endfunction

   initial begin
      tbl[0]  = '{3'd0, 1'b0, 1'b0, 20'hFFFF0};
      tbl[1]  = '{3'd0, 1'b0, 1'b0, 20'hFFFF0};
      tbl[2]  = '{3'd0, 1'b1, 1'b0, 20'hFFFF0};
      tbl[3]  = '{3'd0, 1'b1, 1'b0, 20'hFFFF0};
      tbl[4]  = '{3'd5, 1'b0, 1'b1, 20'hFFFF0};
      tbl[5]  = '{3'd5, 1'b0, 1'b0, 20'hFFFF0};
      tbl[6]  = '{3'd6, 1'b0, 1'b0, 20'hFFFF1};
      tbl[7]  = '{3'd6, 1'b1, 1'b0, 20'hFFFF1};
      tbl[8]  = '{3'd6, 1'b1, 1'b0, 20'hFFFF1};
      tbl[9]  = '{3'd6, 1'b0, 1'b1, 20'hFFFF1};
      tbl[10] = '{3'd6, 1'b0, 1'b0, 20'hFFFF1};
      tbl[11] = '{3'd6, 1'b0, 1'b0, 20'hFFFF1};

      reset         = 1'b0;
      eu_request    = 1'b0;
      eu_write      = 1'b0;
      eu_address    = 20'h0;
      eu_wdata      = 8'h0;
      flush         = 1'b1;
      flush_address = 20'h12345;
      q_length      = 3'd0;
      bus_ready     = 1'b1;

      // reset state, with flush driven to show it is ignored
      cyc();
      cyc();
      @(negedge clock);
      chk("rst_bus_address", {12'h0, bus_address}, 32'h000FFFF0);
      chk("rst_strobes", {bus_read, bus_write}, 0);
      chk("rst_eu_done", eu_done, 0);
      chk("rst_q_write_enable", q_write_enable, 0);
      chk("rst_q_clear", q_clear, 0);
      chk("rst_data", {eu_rdata, q_write_data, bus_wdata}, 0);
      cyc();

      // reset release and first prefetches, cycle by cycle
      pf_q.push_back(pf(20'hFFFF0, 8'h10));
      pf_q.push_back(pf(20'hFFFF1, 8'h11));
      flush = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         q_length = tbl[i].qlen;
         @(negedge clock);
         chk($sformatf("tbl%0d_read", i), bus_read, tbl[i].rd);
         chk($sformatf("tbl%0d_qwe", i), q_write_enable, tbl[i].qwe);
         chk($sformatf("tbl%0d_addr", i), {12'h0, bus_address},
             {12'h0, tbl[i].addr});
         cyc();
      end

      // EU read with a full queue
      eu_cycle(20'h12345, 1'b0, 8'h00, 8'hA5, 1'b0, 3'd6);
      @(negedge clock);
      chk("done_one_cycle", eu_done, 0);
      chk("eu_rdata_held", {24'h0, eu_rdata}, 32'hA5);
      cyc();

      // EU write beats a pending prefetch; prefetch follows T4
      eu_cycle(20'h00ABC, 1'b1, 8'h3C, 8'h3C, 1'b0, 3'd0);
      pf_q.push_back(pf(20'h00400, 8'hE0));
      @(negedge clock);
      chk("pf_after_eu_addr", {12'h0, bus_address}, 32'h000FFFF2);
      chk("pf_after_eu_t1", bus_read, 0);
      cyc();
      flush         = 1'b1;
      flush_address = 20'h00400;
      @(negedge clock);
      chk("flush_t2_read", bus_read, 1);
      chk("flush_q_clear", q_clear, 1);
      cyc();
      flush = 1'b0;
      idle_cycles(1);
      @(negedge clock);
      chk("flushed_no_push", q_write_enable, 0);
      cyc();
      @(negedge clock);
      chk("post_flush_addr", {12'h0, bus_address}, 32'h00000400);
      cyc();
      wait_pushes(1);
      idle_cycles(1);

      // pointer wrap
      flush         = 1'b1;
      flush_address = 20'hFFFFF;
      q_length      = 3'd0;
      @(negedge clock);
      chk("wrap_q_clear", q_clear, 1);
      cyc();
      flush = 1'b0;
      pf_q.push_back(pf(20'hFFFFF, 8'h1F));
      pf_q.push_back(pf(20'h00000, 8'hE0));
      wait_pushes(2);
      idle_cycles(2);

      // flush coinciding with a prefetch T4
      q_length = 3'd0;
      idle_cycles(4);
      flush         = 1'b1;
      flush_address = 20'h0ABCD;
      @(negedge clock);
      chk("t4_flush_no_push", q_write_enable, 0);
      chk("t4_flush_q_clear", q_clear, 1);
      cyc();
      flush = 1'b0;
      pf_q.push_back(pf(20'h0ABCD, 8'h2D));
      idle_cycles(1);
      @(negedge clock);
      chk("t4_flush_new_addr", {12'h0, bus_address}, 32'h0000ABCD);
      cyc();
      wait_pushes(1);
      idle_cycles(2);

      // bus_ready low for two cycles in T3
      eu_cycle(20'h00F00, 1'b0, 8'h00, 8'hE0, 1'b1, 3'd6);
      idle_cycles(2);

      // reset in the middle of an EU cycle aborts it
      begin
         int ev;
         eu_request = 1'b1;
         eu_write   = 1'b0;
         eu_address = 20'h11111;
         idle_cycles(2);
         @(negedge clock);
         chk("abort_pre_read", bus_read, 1);
         #1;
         reset      = 1'b0;
         eu_request = 1'b0;
         #1;
         chk("abort_read", bus_read, 0);
         chk("abort_addr", {12'h0, bus_address}, 32'h000FFFF0);
         cyc();
         reset = 1'b1;
         ev    = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (eu_done || q_write_enable || bus_read) ev++;
            cyc();
         end
         chk("abort_no_events", ev, 0);
      end

      chk("pf_queue_drained", pf_q.size(), 0);
      chk("eu_queue_drained", eu_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/prefetch_scheduler.md
PREFETCH_SCHEDULER -- requirements
Module: prefetch_scheduler

Interface
REQ-001 Parameter WIDTH_ADDR, default 20: physical address width.
REQ-002 Parameter QUEUE_DEPTH, default 6: capacity of the external instruction FIFO, in bytes.
REQ-003 Parameter RESET_ADDRESS, default 20'hFFFF0: prefetch pointer value after reset.
REQ-004 Port clock, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port eu_request / eu_write, input, 1 / 1: EU bus-cycle request; eu_write selects a write (1) or a read (0).
REQ-007 Port eu_address / eu_wdata, input, WIDTH_ADDR / 8: EU cycle address and write data.
REQ-008 Port eu_done / eu_rdata, output, 1 / 8: one-cycle completion pulse; read data.
REQ-009 Port flush / flush_address, input, 1 / WIDTH_ADDR: branch taken; new prefetch address.
REQ-010 Port q_length, input, $clog2(QUEUE_DEPTH+1): current FIFO occupancy.
REQ-011 Port q_write_enable / q_write_data / q_clear, output, 1 / 8 / 1: FIFO push, pushed byte, and FIFO discard pulse.
REQ-012 Port bus_address / bus_wdata, output, WIDTH_ADDR / 8: bus address and write data.
REQ-013 Port bus_read / bus_write, output, 1 / 1: bus strobes.
REQ-014 Port bus_rdata / bus_ready, input, 8 / 1: bus read data; ready, where 0 inserts a wait state.

Function
REQ-015 The FSM SHALL have the states IDLE, T1, T2, T3, TW and T4; each state SHALL last exactly one cycle.
REQ-016 Arbitration SHALL occur in IDLE and in T4.
  - The EU SHALL have priority: if eu_request=1, the next state SHALL be T1 with owner EU.
  - Otherwise, a prefetch SHALL start if the effective occupancy is less than QUEUE_DEPTH and flush=0.
  - Otherwise, the next state SHALL be IDLE.
REQ-017 Effective occupancy SHALL equal q_length + q_write_enable, so the push made in the current cycle is counted.
REQ-018 bus_address SHALL be held stable from T1 through T4: eu_address for an EU cycle, the prefetch pointer for a prefetch.
REQ-019 bus_read or bus_write SHALL be asserted in T2, T3 and TW only.
REQ-020 bus_wdata SHALL hold eu_wdata during T2 through T4 of an EU write cycle.
REQ-021 Read data SHALL be captured at the end of the last T3/TW cycle.
REQ-022 Completion of an EU cycle:
  - eu_done SHALL pulse for exactly one cycle, during T4.
  - eu_rdata SHALL be valid while eu_done=1 and SHALL be held until the next EU read completes.
REQ-023 eu_request SHALL be held high until eu_done.
REQ-024 A request sampled in IDLE at cycle N SHALL produce eu_done at cycle N+4 when no wait states occur.
REQ-025 Completion of a prefetch:
  - q_write_enable SHALL pulse for one cycle in T4, with q_write_data set to the captured byte.
  - The prefetch pointer SHALL increment by 1, wrapping modulo 2^WIDTH_ADDR.
REQ-026 Flush handling:
  - flush=1 SHALL load the prefetch pointer with flush_address.
  - q_clear SHALL pulse in the same cycle as flush.
REQ-027 A prefetch cycle in flight when flush occurs SHALL complete its bus phases, but its byte SHALL be discarded: no q_write_enable and no pointer increment.
REQ-028 If flush coincides with a prefetch T4, the flush SHALL win: no push, and the pointer SHALL become flush_address.
REQ-029 An EU cycle SHALL NOT be affected by flush.
REQ-030 A full queue (effective occupancy equal to QUEUE_DEPTH) SHALL stall prefetching only; EU cycles SHALL proceed normally.

Reset
REQ-031 While reset=0, the following SHALL apply:
  - State SHALL be IDLE and owner SHALL be NONE.
  - The prefetch pointer SHALL equal RESET_ADDRESS.
  - Every output SHALL be 0, except bus_address, which SHALL equal RESET_ADDRESS.
REQ-032 Reset asserted mid-cycle SHALL abort the bus cycle immediately, with no eu_done and no q_write_enable.
REQ-033 The first arbitration after reset deassertion SHALL occur in the first IDLE cycle.

Configuration
REQ-034 With PREFETCH_SCHEDULER_WAIT_STATE_EN defined:
  - T3 SHALL go to TW when bus_ready=0.
  - TW SHALL repeat while bus_ready=0 and SHALL go to T4 when bus_ready=1.
  - T3 SHALL go to T4 when bus_ready=1.
REQ-035 With PREFETCH_SCHEDULER_WAIT_STATE_EN undefined, bus_ready SHALL be ignored, TW SHALL be unreachable, and T3 SHALL always go to T4.

Structure
REQ-036 The shared package biu_pkg SHALL hold the following:
  - the state enum {IDLE, T1, T2, T3, TW, T4};
  - the owner enum {NONE, EU, PF};
  - the WIDTH_ADDR default;
  - the RESET_ADDRESS default.
REQ-037 The sequencing of T1 through T4 SHALL be a sub-module, bus_cycle_fsm, which outputs the state and a one-cycle "cycle_end" pulse in T4.
REQ-038 Arbitration, the prefetch pointer and flush handling SHALL reside in prefetch_scheduler.

Verification
REQ-039 Scenario: reset release with q_length=0 and no EU request -> T1 at the first IDLE+1 cycle with bus_address=FFFF0; first push carries bus_rdata; pointer becomes FFFF1.
REQ-040 Scenario: q_length held at 6 -> no bus_read ever asserted; an EU read of 0x12345 with bus_rdata=0xA5 -> eu_done after 4 cycles with eu_rdata=0xA5.
REQ-041 Scenario: eu_request and prefetch eligibility in the same IDLE cycle -> EU cycle first; prefetch T1 immediately follows the EU T4.
REQ-042 Scenario: flush with flush_address=0x00400 during prefetch T2 -> q_clear in the same cycle; no push at T4; next prefetch address is 0x00400.
REQ-043 Scenario: pointer at FFFFF after a push -> pointer wraps to 00000.
REQ-044 Scenario, wait states enabled: bus_ready=0 for 2 cycles in T3 -> two TW cycles; eu_done at cycle N+6.
